// File: rtl/spu_pkg.sv
// Shared constants, stage entry payload and latency helper for the SPU result forwarding path.
package spu_pkg;

   localparam int unsigned SPU_REG_W     = 7;
   localparam int unsigned SPU_DATA_W    = 128;
   localparam int unsigned SPU_FWD_DEPTH = 7;
   localparam int unsigned SPU_CNT_W     = 3;

   typedef struct packed {
      logic                  valid;
      logic [SPU_CNT_W-1:0]  countdown;
      logic [SPU_REG_W-1:0]  rdst;
      logic [SPU_DATA_W-1:0] data;
   } fwd_entry_t;

   typedef struct packed {
      logic                  hit;
      logic                  pend;
      logic [SPU_DATA_W-1:0] data;
   } fwd_res_t;

   // Countdown loaded at capture: clamp(latency,1,DEPTH)-1
   function automatic logic [SPU_CNT_W-1:0] fwd_clamp_latency(input logic [SPU_CNT_W-1:0] lat);
      int unsigned l;
      l = 32'(lat);
      if (l == 0) l = 1;
      if (l > SPU_FWD_DEPTH) l = SPU_FWD_DEPTH;
      return SPU_CNT_W'(l - 1);
   endfunction

endpackage

// File: rtl/spu_fwd_lane.sv
// One lane of the result return path: a DEPTH-deep shift pipe with per-entry ready countdown.
module spu_fwd_lane
   import spu_pkg::*;
(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              i_we,
   input  logic [SPU_REG_W-1:0]              i_reg,
   input  logic [SPU_DATA_W-1:0]             i_data,
   input  logic [SPU_CNT_W-1:0]              i_lat,
   output fwd_entry_t [SPU_FWD_DEPTH-1:0]    o_stage
);

   fwd_entry_t [SPU_FWD_DEPTH-1:0] r_stage;
   fwd_entry_t [SPU_FWD_DEPTH-1:0] w_next;

   // Bubbles enter with all fields zero; older entries age with a saturating countdown
   always_comb begin
      w_next = '0;
      if (i_we) begin
         w_next[0].valid     = 1'b1;
         w_next[0].countdown = fwd_clamp_latency(i_lat);
         w_next[0].rdst      = i_reg;
         w_next[0].data      = i_data;
      end
      for (int k = 1; k < int'(SPU_FWD_DEPTH); k++) begin
         w_next[k] = r_stage[k-1];
         if (r_stage[k-1].countdown != '0)
            w_next[k].countdown = r_stage[k-1].countdown - SPU_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_stage <= '0;
      else        r_stage <= w_next;
   end

   assign o_stage = r_stage;

endmodule

// File: rtl/spu_result_forward_pipe.sv
// Dual-lane SPU result return pipe: operand forwarding to the REG stage plus register-file writeback.
// SPU_FWD_HAZARD_EN: when defined, a youngest-but-not-ready match raises stall_REGn instead of forwarding.
module spu_result_forward_pipe
   import spu_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  regWriteEnable_EX1,
   input  logic                  regWriteEnable_EX2,
   input  logic [SPU_REG_W-1:0]  writeRegister_EX1,
   input  logic [SPU_REG_W-1:0]  writeRegister_EX2,
   input  logic [SPU_DATA_W-1:0] result_EX1,
   input  logic [SPU_DATA_W-1:0] result_EX2,
   input  logic [SPU_CNT_W-1:0]  latency_EX1,
   input  logic [SPU_CNT_W-1:0]  latency_EX2,
   input  logic [SPU_REG_W-1:0]  readRegisterRA_REG1,
   input  logic [SPU_REG_W-1:0]  readRegisterRB_REG1,
   input  logic [SPU_REG_W-1:0]  readRegisterRC_REG1,
   input  logic [SPU_REG_W-1:0]  readRegisterRA_REG2,
   input  logic [SPU_REG_W-1:0]  readRegisterRB_REG2,
   input  logic [SPU_REG_W-1:0]  readRegisterRC_REG2,
   output logic                  fwdHitRA_REG1,
   output logic                  fwdHitRB_REG1,
   output logic                  fwdHitRC_REG1,
   output logic                  fwdHitRA_REG2,
   output logic                  fwdHitRB_REG2,
   output logic                  fwdHitRC_REG2,
   output logic [SPU_DATA_W-1:0] fwdDataRA_REG1,
   output logic [SPU_DATA_W-1:0] fwdDataRB_REG1,
   output logic [SPU_DATA_W-1:0] fwdDataRC_REG1,
   output logic [SPU_DATA_W-1:0] fwdDataRA_REG2,
   output logic [SPU_DATA_W-1:0] fwdDataRB_REG2,
   output logic [SPU_DATA_W-1:0] fwdDataRC_REG2,
   output logic                  stall_REG1,
   output logic                  stall_REG2,
   output logic                  wbEnable1,
   output logic                  wbEnable2,
   output logic [SPU_REG_W-1:0]  wbRegister1,
   output logic [SPU_REG_W-1:0]  wbRegister2,
   output logic [SPU_DATA_W-1:0] wbData1,
   output logic [SPU_DATA_W-1:0] wbData2
);

   localparam int unsigned DEPTH = SPU_FWD_DEPTH;
   localparam int unsigned REG_W = SPU_REG_W;

   fwd_entry_t [DEPTH-1:0] w_stage1;
   fwd_entry_t [DEPTH-1:0] w_stage2;
   logic [REG_W-1:0]       w_rd   [6];
   fwd_res_t               w_fwd  [6];
   logic                   w_wb_en1;
   logic                   w_wb_en2;

   spu_fwd_lane u_lane1 (
      .clk     (clk),
      .reset   (reset),
      .i_we    (regWriteEnable_EX1),
      .i_reg   (writeRegister_EX1),
      .i_data  (result_EX1),
      .i_lat   (latency_EX1),
      .o_stage (w_stage1)
   );

   spu_fwd_lane u_lane2 (
      .clk     (clk),
      .reset   (reset),
      .i_we    (regWriteEnable_EX2),
      .i_reg   (writeRegister_EX2),
      .i_data  (result_EX2),
      .i_lat   (latency_EX2),
      .o_stage (w_stage2)
   );

   // Youngest stage first, lane 2 ahead of lane 1 within a stage
   function automatic fwd_res_t fwd_lookup(input fwd_entry_t [DEPTH-1:0] l1,
                                           input fwd_entry_t [DEPTH-1:0] l2,
                                           input logic [REG_W-1:0]       ra);
      fwd_res_t   res;
      fwd_entry_t e;
      logic       found;
      res   = '0;
      found = 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         for (int n = 0; n < 2; n++) begin
            e = (n == 0) ? l2[k] : l1[k];
`ifdef SPU_FWD_HAZARD_EN
            if (!found && e.valid && e.rdst == ra) begin
               found    = 1'b1;
               res.hit  = (e.countdown == '0);
               res.pend = (e.countdown != '0);
               res.data = (e.countdown == '0) ? e.data : '0;
            end
`else
            if (!found && e.valid && e.countdown == '0 && e.rdst == ra) begin
               found    = 1'b1;
               res.hit  = 1'b1;
               res.data = e.data;
            end
`endif
         end
      end
      return res;
   endfunction

   assign w_rd[0] = readRegisterRA_REG1;
   assign w_rd[1] = readRegisterRB_REG1;
   assign w_rd[2] = readRegisterRC_REG1;
   assign w_rd[3] = readRegisterRA_REG2;
   assign w_rd[4] = readRegisterRB_REG2;
   assign w_rd[5] = readRegisterRC_REG2;

   always_comb begin
      for (int p = 0; p < 6; p++) begin
         w_fwd[p] = '0;
         w_fwd[p] = fwd_lookup(w_stage1, w_stage2, w_rd[p]);
      end
   end

   assign fwdHitRA_REG1  = w_fwd[0].hit;
   assign fwdHitRB_REG1  = w_fwd[1].hit;
   assign fwdHitRC_REG1  = w_fwd[2].hit;
   assign fwdHitRA_REG2  = w_fwd[3].hit;
   assign fwdHitRB_REG2  = w_fwd[4].hit;
   assign fwdHitRC_REG2  = w_fwd[5].hit;
   assign fwdDataRA_REG1 = w_fwd[0].data;
   assign fwdDataRB_REG1 = w_fwd[1].data;
   assign fwdDataRC_REG1 = w_fwd[2].data;
   assign fwdDataRA_REG2 = w_fwd[3].data;
   assign fwdDataRB_REG2 = w_fwd[4].data;
   assign fwdDataRC_REG2 = w_fwd[5].data;

   // pend is constant 0 without the hazard option, leaving the stalls tied low
   assign stall_REG1 = w_fwd[0].pend | w_fwd[1].pend | w_fwd[2].pend;
   assign stall_REG2 = w_fwd[3].pend | w_fwd[4].pend | w_fwd[5].pend;

   // Same-register collision at writeback: the younger lane 2 result survives
   always_comb begin
      w_wb_en2 = w_stage2[DEPTH-1].valid;
      w_wb_en1 = w_stage1[DEPTH-1].valid &&
                 !(w_wb_en2 && (w_stage2[DEPTH-1].rdst == w_stage1[DEPTH-1].rdst));
   end

   assign wbEnable1   = w_wb_en1;
   assign wbEnable2   = w_wb_en2;
   assign wbRegister1 = w_wb_en1 ? w_stage1[DEPTH-1].rdst : '0;
   assign wbRegister2 = w_wb_en2 ? w_stage2[DEPTH-1].rdst : '0;
   assign wbData1     = w_wb_en1 ? w_stage1[DEPTH-1].data : '0;
   assign wbData2     = w_wb_en2 ? w_stage2[DEPTH-1].data : '0;

endmodule

// File: tb/tb_spu_result_forward_pipe.sv
// Scoreboard bench for spu_result_forward_pipe; expectations follow SPU_FWD_HAZARD_EN when defined.
module tb_spu_result_forward_pipe;

`ifdef SPU_FWD_HAZARD_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   typedef struct { int cyc; int lane; logic [6:0] r; logic [127:0] d; } wb_t;
   typedef struct { int cyc; int port; logic hit; logic [127:0] data; logic stall; } fx_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         we1, we2;
   logic [6:0]   wr1, wr2;
   logic [127:0] res1, res2;
   logic [2:0]   lat1, lat2;
   logic [6:0]   rd [6];
   logic [5:0]   hit;
   logic [127:0] fd [6];
   logic         stall1, stall2;
   logic         wbe1, wbe2;
   logic [6:0]   wbr1, wbr2;
   logic [127:0] wbd1, wbd2;

   int  cyc   = 0;
   int  total = 0;
   int  bad   = 0;
   wb_t wb_q [$];
   fx_t fwd_q [$];

   spu_result_forward_pipe dut (
      .clk(clk), .reset(reset),
      .regWriteEnable_EX1(we1), .regWriteEnable_EX2(we2),
      .writeRegister_EX1(wr1), .writeRegister_EX2(wr2),
      .result_EX1(res1), .result_EX2(res2),
      .latency_EX1(lat1), .latency_EX2(lat2),
      .readRegisterRA_REG1(rd[0]), .readRegisterRB_REG1(rd[1]), .readRegisterRC_REG1(rd[2]),
      .readRegisterRA_REG2(rd[3]), .readRegisterRB_REG2(rd[4]), .readRegisterRC_REG2(rd[5]),
      .fwdHitRA_REG1(hit[0]), .fwdHitRB_REG1(hit[1]), .fwdHitRC_REG1(hit[2]),
      .fwdHitRA_REG2(hit[3]), .fwdHitRB_REG2(hit[4]), .fwdHitRC_REG2(hit[5]),
      .fwdDataRA_REG1(fd[0]), .fwdDataRB_REG1(fd[1]), .fwdDataRC_REG1(fd[2]),
      .fwdDataRA_REG2(fd[3]), .fwdDataRB_REG2(fd[4]), .fwdDataRC_REG2(fd[5]),
      .stall_REG1(stall1), .stall_REG2(stall2),
      .wbEnable1(wbe1), .wbEnable2(wbe2),
      .wbRegister1(wbr1), .wbRegister2(wbr2),
      .wbData1(wbd1), .wbData2(wbd2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic mon_wb(input int lane, input logic en, input logic [6:0] r, input logic [127:0] d);
      wb_t w;
      if (en) begin
         if (wb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected lane%0d cyc=%0d got reg=%0d data=%0h want none", lane, cyc, r, d);
         end else begin
            w = wb_q.pop_front();
            chk("wb_cycle", 128'(cyc), 128'(w.cyc));
            chk("wb_lane", 128'(lane), 128'(w.lane));
            chk("wb_reg", 128'(r), 128'(w.r));
            chk("wb_data", d, w.d);
         end
      end else begin
         chk("wb_idle_reg", 128'(r), 128'h0);
         chk("wb_idle_data", d, 128'h0);
      end
   endtask

   // Monitor: drains writeback and forwarding expectations independently of stimulus
   always @(negedge clk) begin : monitor
      fx_t f;
      mon_wb(1, wbe1, wbr1, wbd1);
      mon_wb(2, wbe2, wbr2, wbd2);
      while (fwd_q.size() > 0 && fwd_q[0].cyc <= cyc) begin
         f = fwd_q.pop_front();
         if (f.cyc != cyc) chk("fwd_late", 128'(cyc), 128'(f.cyc));
         chk($sformatf("fwd_hit_p%0d", f.port), 128'(hit[f.port]), 128'(f.hit));
         chk($sformatf("fwd_data_p%0d", f.port), fd[f.port], f.data);
         chk($sformatf("stall_p%0d", f.port), 128'((f.port < 3) ? stall1 : stall2), 128'(f.stall));
      end
   end

   task automatic issue(input int lane, input logic [6:0] r, input logic [127:0] d,
                        input logic [2:0] lat, input bit exp_wb);
      wb_t w;
      if (lane == 1) begin
         we1 = 1'b1; wr1 = r; res1 = d; lat1 = lat;
      end else begin
         we2 = 1'b1; wr2 = r; res2 = d; lat2 = lat;
      end
      if (exp_wb) begin
         w.cyc = cyc + 7; w.lane = lane; w.r = r; w.d = d;
         wb_q.push_back(w);
      end
   endtask

   task automatic expect_fwd(input int port, input logic [6:0] a, input logic h,
                             input logic [127:0] d, input logic s);
      fx_t f;
      rd[port] = a;
      f.cyc = cyc; f.port = port; f.hit = h; f.data = d; f.stall = s;
      fwd_q.push_back(f);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      we1 = 1'b0;
      we2 = 1'b0;
   endtask

   task automatic park();
      for (int p = 0; p < 6; p++) rd[p] = 7'd127;
   endtask

   task automatic drain();
      next();
      park();
      repeat (8) next();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1);
   end

   initial begin : stim
      // Reset held low with live inputs: nothing may appear
      reset = 1'b0;
      we1 = 1'b1; wr1 = 7'd5; res1 = 128'h55; lat1 = 3'd1;
      we2 = 1'b1; wr2 = 7'd5; res2 = 128'h66; lat2 = 3'd1;
      for (int p = 0; p < 6; p++) rd[p] = 7'd5;
      repeat (2) @(posedge clk);
      #1;
      for (int p = 0; p < 6; p++) expect_fwd(p, 7'd5, 1'b0, 128'h0, 1'b0);
      next();
      reset = 1'b1;
      for (int p = 0; p < 6; p++) expect_fwd(p, 7'd5, 1'b0, 128'h0, 1'b0);
      next();
      for (int p = 0; p < 6; p++) expect_fwd(p, 7'd5, 1'b0, 128'h0, 1'b0);
      next();
      park();

      // Latency 1 forwards from stage 0; r0 forwards like any register
      issue(1, 7'd5, 128'hAA, 3'd1, 1'b1);
      issue(2, 7'd0, 128'hF0, 3'd1, 1'b1);
      next();
      expect_fwd(0, 7'd5, 1'b1, 128'hAA, 1'b0);
      expect_fwd(5, 7'd0, 1'b1, 128'hF0, 1'b0);
      drain();

      // Latency 4: pending for three cycles, then forwarded
      issue(1, 7'd9, 128'h11, 3'd4, 1'b1);
      for (int i = 1; i <= 7; i++) begin
         next();
         expect_fwd(4, 7'd9, (i >= 4), (i >= 4) ? 128'h11 : 128'h0, HZ && (i < 4));
      end
      drain();

      // Same stage, same register: lane 2 wins both forwarding and writeback
      issue(1, 7'd3, 128'h1, 3'd1, 1'b0);
      issue(2, 7'd3, 128'h2, 3'd1, 1'b1);
      next();
      expect_fwd(0, 7'd3, 1'b1, 128'h2, 1'b0);
      drain();

      // Younger not-ready entry shadows an older ready one
      issue(1, 7'd7, 128'hA, 3'd1, 1'b1);
      next();
      expect_fwd(1, 7'd7, 1'b1, 128'hA, 1'b0);
      issue(1, 7'd7, 128'hB, 3'd6, 1'b1);
      for (int i = 2; i <= 7; i++) begin
         next();
         if (i < 7) expect_fwd(1, 7'd7, !HZ, HZ ? 128'h0 : 128'hA, HZ);
         else       expect_fwd(1, 7'd7, 1'b1, 128'hB, 1'b0);
      end
      drain();

      // Latency 0 acts as 1; latency 7 becomes ready only at the writeback stage
      issue(1, 7'd21, 128'h77, 3'd7, 1'b1);
      issue(2, 7'd20, 128'h33, 3'd0, 1'b1);
      for (int i = 1; i <= 7; i++) begin
         next();
         expect_fwd(3, 7'd20, 1'b1, 128'h33, 1'b0);
         expect_fwd(2, 7'd21, (i == 7), (i == 7) ? 128'h77 : 128'h0, HZ && (i < 7));
      end
      drain();

      // Reset pulse with four entries in flight discards them all
      issue(1, 7'd40, 128'h40, 3'd1, 1'b0);
      issue(2, 7'd41, 128'h41, 3'd2, 1'b0);
      next();
      expect_fwd(0, 7'd40, 1'b1, 128'h40, 1'b0);
      issue(1, 7'd42, 128'h42, 3'd3, 1'b0);
      issue(2, 7'd43, 128'h43, 3'd1, 1'b0);
      next();
      reset = 1'b0;
      #1;
      expect_fwd(0, 7'd40, 1'b0, 128'h0, 1'b0);
      expect_fwd(3, 7'd43, 1'b0, 128'h0, 1'b0);
      next();
      next();
      reset = 1'b1;
      for (int i = 0; i < 9; i++) begin
         next();
         expect_fwd(0, 7'd40, 1'b0, 128'h0, 1'b0);
         expect_fwd(4, 7'd41, 1'b0, 128'h0, 1'b0);
         expect_fwd(5, 7'd42, 1'b0, 128'h0, 1'b0);
      end
      drain();

      chk("wb_queue_empty", 128'(wb_q.size()), 128'h0);
      chk("fwd_queue_empty", 128'(fwd_q.size()), 128'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
